mux_operand_loader: RTL

Upstream feeder for `mux_2to1_8bit`. It assembles two WIDTH-bit operands from a bit-serial stream, MSB first, and double-buffers them. It then commits both to the `in0`/`in1` outputs on the same clock edge, so the mux never sees a half-updated operand pair. It also owns the registered `sel` line that drives the mux.

---
 rtl/mux_stage_pkg.sv | 16 +
 rtl/sipo_shift.sv | 26 ++
 rtl/mux_operand_loader.sv | 110 +++++++++++
 3 files changed

// File: rtl/mux_stage_pkg.sv
// Purpose: shared types and constants for the mux operand staging path.
// Contents: MUX_WIDTH (default operand width), loader_state_t (loader FSM
//           states), mux_word_t (one operand word at the default width).
package mux_stage_pkg;

   localparam int MUX_WIDTH = 8;

   typedef enum logic [1:0] {
      LOAD0,
      LOAD1,
      COMMIT
   } loader_state_t;

   typedef logic [MUX_WIDTH-1:0] mux_word_t;

endpackage

// File: rtl/sipo_shift.sv
// Purpose: WIDTH-bit serial-in/parallel-out shift register, MSB first.
// Ports:   clk, clear (sync, wins over shift), shift_en (shift din in at LSB),
//          din (serial bit), q (parallel word).
module sipo_shift
   import mux_stage_pkg::*;
#(
   parameter int WIDTH = MUX_WIDTH
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             shift_en,
   input  logic             din,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (clear) begin
         q <= '0;
      end else if (shift_en) begin
         // Earlier bits move toward the MSB, so the first bit of a word
         // ends up in q[WIDTH-1] after WIDTH shifts.
         q <= {q[WIDTH-2:0], din};
      end
   end

endmodule

// File: rtl/mux_operand_loader.sv
// Purpose: assembles two WIDTH-bit operands from a serial stream, double
//          buffers them, and commits both to in0/in1 on one edge; owns sel.
// Ports:   clk, reset (sync, active-high); ser_in/ser_valid/ser_ready serial
//          handshake; sel_toggle request; in0/in1/sel to the mux; word_done
//          and pair_commit status pulses.
module mux_operand_loader
   import mux_stage_pkg::*;
#(
   parameter int WIDTH = MUX_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ser_in,
   input  logic             ser_valid,
   output logic             ser_ready,
   input  logic             sel_toggle,
   output logic [WIDTH-1:0] in0,
   output logic [WIDTH-1:0] in1,
   output logic             sel,
   output logic             word_done,
   output logic             pair_commit
);

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   loader_state_t    state;
   logic [CW-1:0]    bit_cnt;
   logic [WIDTH-1:0] stage0;
   logic [WIDTH-1:0] stage1;
   logic             accept;
   logic             last_bit;
   logic             shift0;
   logic             shift1;

   // COMMIT is the only state that refuses bits, so any ser_valid there is
   // simply not a handshake: no shift, no count.
   assign ser_ready = (state != COMMIT);
   assign accept    = ser_valid && ser_ready;
   assign last_bit  = accept && (bit_cnt == LAST_BIT);
   assign shift0    = accept && (state == LOAD0);
   assign shift1    = accept && (state == LOAD1);

   // Staging words are cleared only by reset; a full word of shifts
   // overwrites every bit, so no clear is needed between pairs.
   sipo_shift #(.WIDTH(WIDTH)) u_stage0 (
      .clk      (clk),
      .clear    (reset),
      .shift_en (shift0),
      .din      (ser_in),
      .q        (stage0)
   );

   sipo_shift #(.WIDTH(WIDTH)) u_stage1 (
      .clk      (clk),
      .clear    (reset),
      .shift_en (shift1),
      .din      (ser_in),
      .q        (stage1)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= LOAD0;
         bit_cnt     <= '0;
         in0         <= '0;
         in1         <= '0;
         sel         <= 1'b0;
         word_done   <= 1'b0;
         pair_commit <= 1'b0;
      end else begin
         word_done   <= last_bit;
         pair_commit <= 1'b0;

         // sel is independent of the load sequence and toggles in any state.
         if (sel_toggle) begin
            sel <= ~sel;
         end

         if (accept) begin
            bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
         end

         case (state)
            LOAD0: begin
               if (last_bit) begin
                  state <= LOAD1;
               end
            end
            LOAD1: begin
               if (last_bit) begin
                  state <= COMMIT;
               end
            end
            COMMIT: begin
               // Both operands land on the same edge so the mux never sees
               // a mixed old/new pair.
               in0         <= stage0;
               in1         <= stage1;
               pair_commit <= 1'b1;
               state       <= LOAD0;
            end
            default: begin
               state <= LOAD0;
            end
         endcase
      end
   end

endmodule
